// File: rtl/w_input_conditioner_pkg.sv
// rtl/w_input_conditioner_pkg.sv - shared state encodings and defaults for the w input conditioner
package w_input_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_LO     = 2'b00,
    ST_CHK_HI = 2'b01,
    ST_HI     = 2'b10,
    ST_CHK_LO = 2'b11
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/w_input_conditioner_sync_chain.sv
// rtl/w_input_conditioner_sync_chain.sv - plain flip-flop synchroniser for one asynchronous level
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/w_input_conditioner.sv
// rtl/w_input_conditioner.sv - synchronise and debounce raw w, with edge pulses and rise counter
module w_input_conditioner
  import w_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 4,
  parameter int EVT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_raw,
  output logic             w,
  output logic             w_rise,
  output logic             w_fall,
  output logic [EVT_W-1:0] evt_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_sync;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             w_n, rise_n, fall_n;
  logic [EVT_W-1:0] evt_n;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (w_raw),
    .q     (w_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_LO;
      cnt       <= '0;
      w         <= 1'b0;
      w_rise    <= 1'b0;
      w_fall    <= 1'b0;
      evt_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      w         <= w_n;
      w_rise    <= rise_n;
      w_fall    <= fall_n;
      evt_count <= evt_n;
    end
  end

  // cnt defaults to 0 so every path that does not extend a run restarts it
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    w_n     = w;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    evt_n   = evt_count;
    case (state)
      ST_LO: begin
        w_n = 1'b0;
        if (w_sync) begin
          state_n = ST_CHK_HI;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_CHK_HI: begin
        w_n = 1'b0;
        if (!w_sync) begin
          state_n = ST_LO;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_HI;
          w_n     = 1'b1;
          rise_n  = 1'b1;
          evt_n   = evt_count + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_HI: begin
        w_n = 1'b1;
        if (!w_sync) begin
          state_n = ST_CHK_LO;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_CHK_LO: begin
        w_n = 1'b1;
        if (w_sync) begin
          state_n = ST_HI;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_LO;
          w_n     = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_LO;
        w_n     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_w_input_conditioner.sv
// tb/tb_w_input_conditioner.sv - self-checking bench for w_input_conditioner
`timescale 1ns/100ps
module tb_w_input_conditioner;
  import w_input_conditioner_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       w_raw = 1'b0;
  logic       w, w_rise, w_fall;
  logic [7:0] evt_count;

  always #1 clk = ~clk;

  w_input_conditioner dut (
    .clk       (clk),
    .reset     (reset),
    .w_raw     (w_raw),
    .w         (w),
    .w_rise    (w_rise),
    .w_fall    (w_fall),
    .evt_count (evt_count)
  );

  typedef struct {
    logic       w;
    logic       rise;
    logic       fall;
    logic [7:0] evt;
  } exp_t;

  typedef struct {
    logic       raw;
    logic       w;
    logic       rise;
    logic [7:0] evt;
  } vec_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rise_total = 0;
  int   fall_total = 0;

  // reference: level flips after DEB consecutive synced samples that disagree with it
  logic [SYNC-1:0] m_sp;
  logic            m_w;
  int              m_run;
  logic [7:0]      m_evt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_sp  = '0;
    m_w   = 1'b0;
    m_run = 0;
    m_evt = '0;
  endtask

  task automatic step(input logic raw);
    exp_t e, got;
    logic seen;
    @(negedge clk);
    w_raw = raw;
    @(posedge clk);
    #0.5;
    e.rise = 1'b0;
    e.fall = 1'b0;
    if (!reset) begin
      model_clear();
    end else begin
      seen = m_sp[SYNC-1];
      m_sp = {m_sp[SYNC-2:0], raw};
      m_run = (seen != m_w) ? m_run + 1 : 0;
      if (m_run == DEB) begin
        m_w   = seen;
        m_run = 0;
        if (seen) begin
          e.rise = 1'b1;
          m_evt  = m_evt + 8'd1;
        end else begin
          e.fall = 1'b1;
        end
      end
    end
    e.w   = m_w;
    e.evt = m_evt;
    sbq.push_back(e);
    if (w_rise) rise_total++;
    if (w_fall) fall_total++;
    got = sbq.pop_front();
    n_tests++;
    if (w !== got.w || w_rise !== got.rise || w_fall !== got.fall || evt_count !== got.evt) begin
      n_fail++;
      $display("FAIL scoreboard @%0t: got w=%b r=%b f=%b evt=%0d expected w=%b r=%b f=%b evt=%0d",
               $time, w, w_rise, w_fall, evt_count, got.w, got.rise, got.fall, got.evt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    w_raw = 1'b0;
    model_clear();
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t vecs[14];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [7:0] evt0;
    model_clear();

    // 1: held in reset while raw toggles, then release with raw high
    #0.3;
    check("t1_reset_w", 32'(w), 32'd0);
    check("t1_reset_evt", 32'(evt_count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step((i % 2) == 0);
    end
    check("t1_in_reset_w", 32'(w), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    do begin
      step(1'b1);
      n++;
    end while (w !== 1'b1 && n < 20);
    check("t1_latency_edges", 32'(n), 32'(1 + SYNC + DEB - 1));
    check("t1_rise_pulse", 32'(w_rise), 32'd1);
    check("t1_evt", 32'(evt_count), 32'd1);
    step(1'b1);
    check("t1_rise_one_cycle", 32'(w_rise), 32'd0);

    // 2: clean fall then clean rise, one pulse each
    rise_total = 0;
    fall_total = 0;
    n = 0;
    do begin
      step(1'b0);
      n++;
    end while (w !== 1'b0 && n < 20);
    check("t2_fall_latency", 32'(n), 32'(SYNC + DEB));
    check("t2_fall_pulse", 32'(w_fall), 32'd1);
    for (int i = n; i < 10; i++) step(1'b0);
    n = 0;
    do begin
      step(1'b1);
      n++;
    end while (w !== 1'b1 && n < 20);
    check("t2_rise_latency", 32'(n), 32'(SYNC + DEB));
    for (int i = n; i < 10; i++) step(1'b1);
    check("t2_rise_count", 32'(rise_total), 32'd1);
    check("t2_fall_count", 32'(fall_total), 32'd1);

    // 3: 1- and 3-cycle glitches from ST_LO are rejected
    for (int i = 0; i < 10; i++) step(1'b0);
    evt0 = evt_count;
    step(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0);
    check("t3_w_low", 32'(w), 32'd0);
    check("t3_evt_same", 32'(evt_count), 32'(evt0));
    check("t3_state_lo", 32'(dut.state), 32'(ST_LO));

    // 4: chatter table, one rise after the final four synced ones
    vecs = '{
      '{1'b1, 1'b0, 1'b0, 8'd0}, '{1'b0, 1'b0, 1'b0, 8'd0}, '{1'b1, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b0, 1'b0, 8'd0}, '{1'b0, 1'b0, 1'b0, 8'd0}, '{1'b1, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b0, 1'b0, 8'd0}, '{1'b1, 1'b0, 1'b0, 8'd0}, '{1'b1, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b0, 1'b0, 8'd0}, '{1'b1, 1'b1, 1'b1, 8'd1}, '{1'b1, 1'b1, 1'b0, 8'd1},
      '{1'b1, 1'b1, 1'b0, 8'd1}, '{1'b1, 1'b1, 1'b0, 8'd1}
    };
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].raw);
      check($sformatf("t4_vec%0d_w", i), 32'(w), 32'(vecs[i].w));
      check($sformatf("t4_vec%0d_rise", i), 32'(w_rise), 32'(vecs[i].rise));
      check($sformatf("t4_vec%0d_evt", i), 32'(evt_count), 32'(vecs[i].evt));
    end

    // 5: asynchronous reset mid-debounce clears before the next edge
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1);
    check("t5_cnt_setup", 32'(dut.cnt), 32'd2);
    check("t5_state_setup", 32'(dut.state), 32'(ST_CHK_HI));
    #0.25;
    reset = 1'b0;
    model_clear();
    #0.1;
    check("t5_async_state", 32'(dut.state), 32'(ST_LO));
    check("t5_async_cnt", 32'(dut.cnt), 32'd0);
    check("t5_async_w", 32'(w), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1);
    @(negedge clk);
    reset = 1'b1;
    rise_total = 0;
    for (int i = 0; i < 10; i++) step(1'b0);
    check("t5_no_rise", 32'(rise_total), 32'd0);
    check("t5_evt", 32'(evt_count), 32'd0);

    // 6: evt_count wraps after 256 accepted rises
    do_reset();
    rise_total = 0;
    for (int p = 1; p <= 257; p++) begin
      for (int i = 0; i < 6; i++) step(1'b1);
      for (int i = 0; i < 6; i++) step(1'b0);
      if (p == 256) check("t6_wrap_256", 32'(evt_count), 32'd0);
    end
    check("t6_evt_257", 32'(evt_count), 32'd1);
    check("t6_rise_total", 32'(rise_total), 32'd257);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
